pbch_re_index_gen: RTL and testbench

PBCH_RE_INDEX_GEN -- requirements
Module: pbch_re_index_gen

---
 rtl/pbch_re_index_gen_if.sv | 30 +++
 rtl/pbch_re_index_gen.sv | 166 ++++++++++++++++
 tb/tb_pbch_re_index_gen.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/pbch_re_index_gen_if.sv
// Request/response bundle for the PBCH RE index generator.
// The master side requests a sequence and accepts indices; the slave side is the generator.
interface pbch_re_index_gen_if #(
  parameter int IDX_W = 10
);
  logic             start;
  logic             abort;
  logic [9:0]       ncellid;
  logic             mode;
  logic             out_ready;
  logic             out_valid;
  logic [IDX_W-1:0] fft_addr;
  logic [IDX_W-1:0] ch_addr;
  logic [1:0]       out_sym;
  logic [7:0]       out_k;
  logic [8:0]       out_seq;
  logic             out_last;
  logic             busy;
  logic             done;

  modport master (
    output start, abort, ncellid, mode, out_ready,
    input  out_valid, fft_addr, ch_addr, out_sym, out_k, out_seq, out_last, busy, done
  );

  modport slave (
    input  start, abort, ncellid, mode, out_ready,
    output out_valid, fft_addr, ch_addr, out_sym, out_k, out_seq, out_last, busy, done
  );
endinterface

// File: rtl/pbch_re_index_gen.sv
// Walks the PBCH data or DMRS resource elements of one SSB and emits buffer addresses.
// First index one cycle after start, one index per accepted cycle; outputs hold while out_ready is low.
module pbch_re_index_gen #(
  parameter int IDX_W      = 10,
  parameter int SYM_STRIDE = 256,
  parameter int K_OFFSET   = 8,
  parameter int CH_OFFSET  = 576
) (
  input logic                clk,
  input logic                rst,
  pbch_re_index_gen_if.slave bus
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [1:0]       v_q, v_d;
  logic             mode_q, mode_d;
  logic [1:0]       sym_q, sym_d;
  logic [7:0]       k_q, k_d;
  logic [8:0]       seq_q, seq_d;
  logic             vld_q, vld_d;
  logic             last_q, last_d;
  logic             done_q, done_d;
  logic [IDX_W-1:0] fft_q, fft_d;
  logic [IDX_W-1:0] ch_q, ch_d;

  logic [7:0] fk, nk, el_k;
  logic [8:0] cand, el_seq;
  logic [1:0] ns, el_sym;
  logic       el_load, el_clear;

  // Only ncellid mod 4 matters for the DMRS comb position.
  logic unused_ncellid_hi;
  assign unused_ncellid_hi = ^bus.ncellid[9:2];

  function automatic logic [7:0] first_k(input logic [1:0] v, input logic md);
    if (md) return {6'd0, v};
    return (v == 2'd0) ? 8'd1 : 8'd0;
  endfunction

  // Successor of the current element: DMRS steps by 4, data skips the one DMRS slot per group of 4.
  always_comb begin
    fk   = first_k(v_q, mode_q);
    cand = {1'b0, k_q} + (mode_q ? 9'd4 : 9'd1);
    if (!mode_q && cand[1:0] == v_q) cand = cand + 9'd1;
    nk = cand[7:0];
    ns = sym_q;
    if (cand >= 9'd240) begin
      nk = fk;
      ns = sym_q + 2'd1;
    end else if (sym_q == 2'd1 && cand >= 9'd48 && cand < 9'd192) begin
      nk = 8'd192 + fk;
    end
  end

  always_comb begin
    state_d  = state_q;
    v_d      = v_q;
    mode_d   = mode_q;
    sym_d    = sym_q;
    k_d      = k_q;
    seq_d    = seq_q;
    vld_d    = vld_q;
    last_d   = last_q;
    fft_d    = fft_q;
    ch_d     = ch_q;
    done_d   = 1'b0;
    el_load  = 1'b0;
    el_clear = 1'b0;
    el_k     = nk;
    el_sym   = ns;
    el_seq   = seq_q + 9'd1;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          v_d     = bus.ncellid[1:0];
          mode_d  = bus.mode;
          state_d = RUN;
          el_load = 1'b1;
          el_k    = first_k(bus.ncellid[1:0], bus.mode);
          el_sym  = 2'd0;
          el_seq  = 9'd0;
        end
      end
      RUN: begin
        if (bus.out_ready) begin
          if (last_q) begin
            state_d  = IDLE;
            el_clear = 1'b1;
            done_d   = 1'b1;
          end else begin
            el_load = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Abort wins over start and acceptance, and suppresses done.
    if (bus.abort) begin
      state_d  = IDLE;
      el_load  = 1'b0;
      el_clear = 1'b1;
      done_d   = 1'b0;
    end

    if (el_load) begin
      vld_d  = 1'b1;
      k_d    = el_k;
      sym_d  = el_sym;
      seq_d  = el_seq;
      last_d = (el_seq == (mode_d ? 9'd143 : 9'd431));
      fft_d  = IDX_W'(K_OFFSET + 32'(el_k) + 32'(el_sym) * SYM_STRIDE);
      ch_d   = IDX_W'(CH_OFFSET + 32'(el_k));
    end else if (el_clear) begin
      vld_d  = 1'b0;
      k_d    = '0;
      sym_d  = '0;
      seq_d  = '0;
      last_d = 1'b0;
      fft_d  = '0;
      ch_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      v_q     <= '0;
      mode_q  <= 1'b0;
      sym_q   <= '0;
      k_q     <= '0;
      seq_q   <= '0;
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      fft_q   <= '0;
      ch_q    <= '0;
    end else begin
      state_q <= state_d;
      v_q     <= v_d;
      mode_q  <= mode_d;
      sym_q   <= sym_d;
      k_q     <= k_d;
      seq_q   <= seq_d;
      vld_q   <= vld_d;
      last_q  <= last_d;
      done_q  <= done_d;
      fft_q   <= fft_d;
      ch_q    <= ch_d;
    end
  end

  assign bus.out_valid = vld_q;
  assign bus.fft_addr  = fft_q;
  assign bus.ch_addr   = ch_q;
  assign bus.out_sym   = sym_q;
  assign bus.out_k     = k_q;
  assign bus.out_seq   = seq_q;
  assign bus.out_last  = last_q;
  assign bus.busy      = (state_q == RUN);
  assign bus.done      = done_q;

endmodule

// File: tb/tb_pbch_re_index_gen.sv
// Randomized bench: every presented index is compared with a list built from the RE allocation rules.
module tb_pbch_re_index_gen;
  localparam int IDX_W = 10;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pbch_re_index_gen_if #(.IDX_W(IDX_W)) ifc ();

  pbch_re_index_gen #(
    .IDX_W(IDX_W), .SYM_STRIDE(256), .K_OFFSET(8), .CH_OFFSET(576)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(ifc)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef logic [39:0] elem_t;
  elem_t exp_q[$];

  elem_t      obs_el;
  logic [2:0] obs_st;
  assign obs_el = {ifc.fft_addr, ifc.ch_addr, ifc.out_sym, ifc.out_k, ifc.out_seq, ifc.out_last};
  assign obs_st = {ifc.out_valid, ifc.busy, ifc.done};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference list: every allowed RE of the three symbols whose DMRS-ness matches the mode.
  task automatic build_model(input logic [9:0] nc, input bit md);
    int v;
    bit allowed, is_dmrs;
    v = int'(nc) % 4;
    exp_q.delete();
    for (int s = 0; s < 3; s++)
      for (int k = 0; k < 240; k++) begin
        allowed = (s != 1) || (k <= 47) || (k >= 192);
        is_dmrs = ((k % 4) == v);
        if (allowed && (is_dmrs == md))
          exp_q.push_back({10'(8 + k + s * 256), 10'(576 + k), 2'(s), 8'(k),
                           9'(exp_q.size()), 1'b0});
      end
    exp_q[exp_q.size() - 1][0] = 1'b1;
  endtask

  task automatic kick(input logic [9:0] nc, input bit md);
    ifc.start   = 1'b1;
    ifc.ncellid = nc;
    ifc.mode    = md;
  endtask

  // Entered at the negedge where start was raised; returns on a negedge.
  task automatic run_body(input logic [9:0] nc, input bit md, input int pct, input int bp_at,
                          input int abort_at, input bit chain, input logic [9:0] nc2,
                          input bit md2);
    int idx = 0;
    int hold = 0;
    bit bp_used = 1'b0;
    bit fin = 1'b0;
    bit rdy;
    build_model(nc, md);
    for (int cyc = 0; cyc < 4000 && !fin; cyc++) begin
      @(negedge clk);
      ifc.start = 1'b0;
      ifc.abort = 1'b0;
      if (idx >= exp_q.size()) begin
        chk("done_state", 64'(obs_st), 64'(3'b001));
        chk("idle_zero", 64'(obs_el), 64'd0);
        fin = 1'b1;
        if (chain) kick(nc2, md2);
        else begin
          @(negedge clk);
          chk("done_once", 64'(obs_st), 64'd0);
        end
      end else begin
        chk("run_state", 64'(obs_st), 64'(3'b110));
        chk("element", 64'(obs_el), 64'(exp_q[idx]));
        if (idx == abort_at) begin
          ifc.abort     = 1'b1;
          ifc.start     = 1'b1;
          ifc.ncellid   = 10'($urandom);
          ifc.out_ready = 1'b1;
          @(negedge clk);
          ifc.abort = 1'b0;
          ifc.start = 1'b0;
          chk("abort_state", 64'(obs_st), 64'd0);
          chk("abort_zero", 64'(obs_el), 64'd0);
          @(negedge clk);
          chk("abort_nodone", 64'(obs_st), 64'd0);
          fin = 1'b1;
        end else begin
          // Stray starts while running must be ignored.
          ifc.start   = ($urandom_range(7) == 0);
          ifc.ncellid = 10'($urandom);
          ifc.mode    = 1'($urandom);
          if (idx == bp_at && !bp_used) begin
            hold    = 3;
            bp_used = 1'b1;
          end
          if (hold > 0) begin
            rdy = 1'b0;
            hold--;
          end else begin
            rdy = ($urandom_range(99) < pct);
          end
          ifc.out_ready = rdy;
          if (rdy) idx++;
        end
      end
    end
    if (!fin) chk("timeout", 64'd0, 64'd1);
  endtask

  initial begin
    logic [9:0] nc;
    bit md;
    ifc.start     = 1'b0;
    ifc.abort     = 1'b0;
    ifc.ncellid   = '0;
    ifc.mode      = 1'b0;
    ifc.out_ready = 1'b0;

    #1;
    chk("reset_state", 64'(obs_st), 64'd0);
    chk("reset_elem", 64'(obs_el), 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      ifc.out_ready = 1'($urandom);
      @(negedge clk);
      chk("post_reset_state", 64'(obs_st), 64'd0);
      chk("post_reset_elem", 64'(obs_el), 64'd0);
    end

    // Data mode cell 0, then DMRS cell 7 started in the done cycle.
    kick(10'd0, 1'b0);
    run_body(10'd0, 1'b0, 100, -1, -1, 1'b1, 10'd7, 1'b1);
    run_body(10'd7, 1'b1, 100, -1, -1, 1'b0, 10'd0, 1'b0);

    // Forced 3-cycle stall at element 5 on top of random backpressure.
    nc = 10'($urandom);
    kick(nc, 1'b0);
    run_body(nc, 1'b0, 70, 5, -1, 1'b0, 10'd0, 1'b0);

    // Abort at element 100 coincident with start, then a clean restart.
    nc = 10'($urandom);
    kick(nc, 1'b1);
    run_body(nc, 1'b1, 60, -1, 100, 1'b0, 10'd0, 1'b0);
    kick(nc, 1'b1);
    run_body(nc, 1'b1, 80, -1, -1, 1'b0, 10'd0, 1'b0);

    // Asynchronous reset in the middle of a sequence.
    nc = 10'($urandom);
    kick(nc, 1'b0);
    @(negedge clk);
    ifc.start     = 1'b0;
    ifc.out_ready = 1'b1;
    repeat (20) @(negedge clk);
    chk("pre_reset_busy", 64'(obs_st), 64'(3'b110));
    #2 rst = 1'b0;
    #1;
    chk("async_reset_state", 64'(obs_st), 64'd0);
    chk("async_reset_elem", 64'(obs_el), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_discard_state", 64'(obs_st), 64'd0);
    chk("reset_discard_elem", 64'(obs_el), 64'd0);

    for (int t = 0; t < 4; t++) begin
      nc = 10'($urandom);
      md = 1'($urandom);
      kick(nc, md);
      run_body(nc, md, $urandom_range(100, 30), -1, -1, 1'b0, 10'd0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
